qdq_scale_pairer: RTL and testbench

Parametrised scale-vector scheduler between the A/B quantizers' scale outputs and the scale cross-product / scale FIFO stage of the QDQ path. It buffers A and B per-tile scale vectors in independent queues and pairs them into (A, B) scale tuples. It supports 1:1 pairing and A-reuse tiling, where one A vector is paired with N consecutive B vectors. Each pair carries a wrapping tag and a last-of-A flag, and the block has a synchronous flush.

---
 rtl/qdq_scale_pairer_pkg.sv | 22 ++
 rtl/qdq_scale_pairer_queue.sv | 59 +++++
 rtl/qdq_scale_pairer.sv | 126 ++++++++++++
 tb/tb_qdq_scale_pairer.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qdq_scale_pairer_pkg.sv
// Shared QDQ scale-path helpers: width arithmetic and the field ordering of
// a packed scale entry ({mantissa vector, exponent vector}, exponent at bit 0).
package qdq_scale_pairer_pkg;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int vec_w(input int mat_size, input int elem_w);
        return mat_size * elem_w;
    endfunction

    localparam int EXP_LSB = 0;

    function automatic int mant_lsb(input int mat_size, input int exp_w);
        return vec_w(mat_size, exp_w);
    endfunction

endpackage

// File: rtl/qdq_scale_pairer_queue.sv
// Circular scale-vector queue with explicit wrap at DEPTH-1 (any depth),
// occupancy count and synchronous flush.
module scale_vec_queue
    import qdq_scale_pairer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [W-1:0]                push_data,
    input  logic                        pop,
    output logic [W-1:0]                head_data,
    output logic                        head_valid,
    output logic                        full,
    output logic [clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W  = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int CNT_QW = clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + PTR_W'(1);
    endfunction

    assign full       = (count == CNT_QW'(DEPTH));
    assign head_valid = (count != '0);
    assign head_data  = mem[rd_ptr];

    // NOTE: storage has no reset; count gates head_valid, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state uses <= so every register samples pre-edge values regardless of statement order.
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      count <= count + CNT_QW'(1);
            else if (!push && pop) count <= count - CNT_QW'(1);
        end
    end

endmodule

// File: rtl/qdq_scale_pairer.sv
// Pairs A and B per-tile scale vectors into (A, B) tuples, with A-reuse
// tiling, a wrapping pair tag, a last-of-A flag and synchronous flush.
module qdq_scale_pairer
    import qdq_scale_pairer_pkg::*;
#(
    parameter int MAT_SIZE  = 16,
    parameter int FP_MANT_W = 23,
    parameter int FP_EXP_W  = 8,
    parameter int A_DEPTH   = 2,
    parameter int B_DEPTH   = 4,
    parameter int CNT_W     = 8,
    parameter int TAG_W     = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [CNT_W-1:0]                  cfg_reuse_i,
    input  logic                              cfg_flush_i,
    input  logic                              a_valid_i,
    output logic                              a_ready_o,
    input  logic [vec_w(MAT_SIZE,FP_MANT_W)-1:0] a_mant_i,
    input  logic [vec_w(MAT_SIZE,FP_EXP_W)-1:0]  a_exp_i,
    input  logic                              b_valid_i,
    output logic                              b_ready_o,
    input  logic [vec_w(MAT_SIZE,FP_MANT_W)-1:0] b_mant_i,
    input  logic [vec_w(MAT_SIZE,FP_EXP_W)-1:0]  b_exp_i,
    output logic                              p_valid_o,
    input  logic                              p_ready_i,
    output logic [vec_w(MAT_SIZE,FP_MANT_W)-1:0] p_a_mant_o,
    output logic [vec_w(MAT_SIZE,FP_EXP_W)-1:0]  p_a_exp_o,
    output logic [vec_w(MAT_SIZE,FP_MANT_W)-1:0] p_b_mant_o,
    output logic [vec_w(MAT_SIZE,FP_EXP_W)-1:0]  p_b_exp_o,
    output logic [TAG_W-1:0]                  p_tag_o,
    output logic                              p_last_o,
    output logic [clog2(A_DEPTH+1)-1:0]       a_count_o,
    output logic [clog2(B_DEPTH+1)-1:0]       b_count_o,
    output logic                              busy_o
);
    localparam int MV_W     = vec_w(MAT_SIZE, FP_MANT_W);
    localparam int EV_W     = vec_w(MAT_SIZE, FP_EXP_W);
    localparam int QW       = MV_W + EV_W;
    localparam int MANT_LSB = mant_lsb(MAT_SIZE, FP_EXP_W);

    logic [QW-1:0]    a_head, b_head;
    logic             a_head_valid, b_head_valid;
    logic             a_full, b_full;
    logic             a_push, b_push, a_pop, b_pop;
    logic             issue, last;
    logic [CNT_W-1:0] reuse_cnt, reuse_lat, reuse_eff, lat_now;
    logic [TAG_W-1:0] tag_q;

    assign a_ready_o = !a_full && !cfg_flush_i;
    assign b_ready_o = !b_full && !cfg_flush_i;
    assign a_push    = a_valid_i && a_ready_o;
    assign b_push    = b_valid_i && b_ready_o;
    assign b_pop     = issue;
    assign a_pop     = issue && last;
    assign busy_o    = (a_count_o != '0) || (b_count_o != '0) || p_valid_o;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        reuse_eff = cfg_reuse_i;
        lat_now   = reuse_lat;
        issue     = 1'b0;
        last      = 1'b0;
        if (cfg_reuse_i == '0) reuse_eff = CNT_W'(1);
        // The reuse factor is sampled only when a new A vector starts pairing.
        if (reuse_cnt == '0) lat_now = reuse_eff;
        issue = a_head_valid && b_head_valid && (!p_valid_o || p_ready_i) && !cfg_flush_i;
        last  = (reuse_cnt == lat_now - CNT_W'(1));
    end

    scale_vec_queue #(.DEPTH(A_DEPTH), .W(QW)) u_a_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (cfg_flush_i),
        .push       (a_push),
        .push_data  ({a_mant_i, a_exp_i}),
        .pop        (a_pop),
        .head_data  (a_head),
        .head_valid (a_head_valid),
        .full       (a_full),
        .count      (a_count_o)
    );

    scale_vec_queue #(.DEPTH(B_DEPTH), .W(QW)) u_b_queue (
        .clk        (clk),
        .rst        (rst),
        .flush      (cfg_flush_i),
        .push       (b_push),
        .push_data  ({b_mant_i, b_exp_i}),
        .pop        (b_pop),
        .head_data  (b_head),
        .head_valid (b_head_valid),
        .full       (b_full),
        .count      (b_count_o)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst || cfg_flush_i) begin
            p_valid_o  <= 1'b0;
            p_last_o   <= 1'b0;
            p_tag_o    <= '0;
            p_a_mant_o <= '0;
            p_a_exp_o  <= '0;
            p_b_mant_o <= '0;
            p_b_exp_o  <= '0;
            tag_q      <= '0;
            reuse_cnt  <= '0;
            reuse_lat  <= '0;
        end else if (issue) begin
            p_valid_o  <= 1'b1;
            p_last_o   <= last;
            p_tag_o    <= tag_q;
            p_a_mant_o <= a_head[MANT_LSB +: MV_W];
            p_a_exp_o  <= a_head[EXP_LSB +: EV_W];
            p_b_mant_o <= b_head[MANT_LSB +: MV_W];
            p_b_exp_o  <= b_head[EXP_LSB +: EV_W];
            tag_q      <= tag_q + TAG_W'(1);
            if (reuse_cnt == '0) reuse_lat <= reuse_eff;
            reuse_cnt  <= last ? '0 : reuse_cnt + CNT_W'(1);
        end else if (p_ready_i) begin
            p_valid_o  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qdq_scale_pairer.sv
// Scoreboard bench for qdq_scale_pairer: odd queue depths, 2-bit tag,
// small vectors so wrap, reuse, backpressure, flush and reset are all reached.
module tb_qdq_scale_pairer;

    localparam int MS = 2;
    localparam int MW = 23;
    localparam int EW = 8;
    localparam int AD = 3;
    localparam int BD = 5;
    localparam int CW = 8;
    localparam int TW = 2;
    localparam int MV = MS * MW;
    localparam int EV = MS * EW;

    typedef struct {
        logic [MV-1:0] am;
        logic [EV-1:0] ae;
        logic [MV-1:0] bm;
        logic [EV-1:0] be;
        logic [TW-1:0] tag;
        logic          last;
    } pair_t;

    logic          clk;
    logic          rst;
    logic [CW-1:0] cfg_reuse_i;
    logic          cfg_flush_i;
    logic          a_valid_i, a_ready_o, b_valid_i, b_ready_o;
    logic [MV-1:0] a_mant_i, b_mant_i, p_a_mant_o, p_b_mant_o;
    logic [EV-1:0] a_exp_i, b_exp_i, p_a_exp_o, p_b_exp_o;
    logic          p_valid_o, p_ready_i, p_last_o, busy_o;
    logic [TW-1:0] p_tag_o;
    logic [1:0]    a_count_o;
    logic [2:0]    b_count_o;

    logic [MV-1:0] a_m [64];
    logic [EV-1:0] a_e [64];
    logic [MV-1:0] b_m [64];
    logic [EV-1:0] b_e [64];
    pair_t         sb [$];
    logic [TW-1:0] exp_tag;
    int            checks;
    int            errors;

    qdq_scale_pairer #(
        .MAT_SIZE(MS), .FP_MANT_W(MW), .FP_EXP_W(EW),
        .A_DEPTH(AD), .B_DEPTH(BD), .CNT_W(CW), .TAG_W(TW)
    ) dut (
        .clk(clk), .rst(rst), .cfg_reuse_i(cfg_reuse_i), .cfg_flush_i(cfg_flush_i),
        .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_mant_i(a_mant_i), .a_exp_i(a_exp_i),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_mant_i(b_mant_i), .b_exp_i(b_exp_i),
        .p_valid_o(p_valid_o), .p_ready_i(p_ready_i),
        .p_a_mant_o(p_a_mant_o), .p_a_exp_o(p_a_exp_o),
        .p_b_mant_o(p_b_mant_o), .p_b_exp_o(p_b_exp_o),
        .p_tag_o(p_tag_o), .p_last_o(p_last_o),
        .a_count_o(a_count_o), .b_count_o(b_count_o), .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each accepted pair (valid and ready seen mid-cycle) is checked against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && p_valid_o && p_ready_i) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pair: got tag=%0d last=%0b, required no pair", p_tag_o, p_last_o);
            end else begin
                pair_t e;
                e = sb.pop_front();
                if ({p_a_mant_o, p_a_exp_o, p_b_mant_o, p_b_exp_o, p_tag_o, p_last_o}
                    !== {e.am, e.ae, e.bm, e.be, e.tag, e.last}) begin
                    errors++;
                    $display("FAIL pair: got am=%h ae=%h bm=%h be=%h tag=%0d last=%0b, required am=%h ae=%h bm=%h be=%h tag=%0d last=%0b",
                             p_a_mant_o, p_a_exp_o, p_b_mant_o, p_b_exp_o, p_tag_o, p_last_o,
                             e.am, e.ae, e.bm, e.be, e.tag, e.last);
                end
            end
        end
    end

    task automatic predict(input int a_start, input int b_start, input int nb, input int reuse);
        int r;
        r = (reuse == 0) ? 1 : reuse;
        for (int j = 0; j < nb; j++) begin
            pair_t e;
            e.am   = a_m[a_start + j / r];
            e.ae   = a_e[a_start + j / r];
            e.bm   = b_m[b_start + j];
            e.be   = b_e[b_start + j];
            e.tag  = exp_tag;
            e.last = ((j % r) == r - 1);
            exp_tag = exp_tag + 1'b1;
            sb.push_back(e);
        end
    endtask

    // Streams A/B vectors through the handshakes until all are accepted and
    // the scoreboard has shrunk to 'keep' entries; starts and ends 1 after posedge.
    task automatic run_stream(input int a_start, input int na, input int b_start, input int nb,
                              input int keep, input int budget);
        int ai, bi, cyc;
        ai = 0; bi = 0; cyc = 0;
        while ((ai < na || bi < nb || sb.size() > keep) && cyc < budget) begin
            a_valid_i = (ai < na);
            a_mant_i  = (ai < na) ? a_m[a_start + ai] : '0;
            a_exp_i   = (ai < na) ? a_e[a_start + ai] : '0;
            b_valid_i = (bi < nb);
            b_mant_i  = (bi < nb) ? b_m[b_start + bi] : '0;
            b_exp_i   = (bi < nb) ? b_e[b_start + bi] : '0;
            @(negedge clk);
            if (a_valid_i && a_ready_o) ai++;
            if (b_valid_i && b_ready_o) bi++;
            @(posedge clk);
            #1;
            cyc++;
        end
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        if (cyc >= budget) begin
            checks++;
            errors++;
            $display("FAIL stream_timeout: got a=%0d/%0d b=%0d/%0d pending=%0d, required completion in %0d cycles",
                     ai, na, bi, nb, sb.size(), budget);
        end
    endtask

    task automatic check_reset_values(input string tag);
        checks++;
        if ({p_valid_o, p_last_o, p_tag_o} !== '0) begin
            errors++;
            $display("FAIL %s_ctrl: got valid=%0b last=%0b tag=%0d, required 0 0 0", tag, p_valid_o, p_last_o, p_tag_o);
        end
        checks++;
        if ({p_a_mant_o, p_a_exp_o, p_b_mant_o, p_b_exp_o} !== '0) begin
            errors++;
            $display("FAIL %s_data: got nonzero pair data, required 0", tag);
        end
        checks++;
        if (a_count_o !== 2'd0 || b_count_o !== 3'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL %s_counts: got a=%0d b=%0d busy=%0b, required 0 0 0", tag, a_count_o, b_count_o, busy_o);
        end
        checks++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: got a=%0b b=%0b, required 1 1", tag, a_ready_o, b_ready_o);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_one_to_one;
        cfg_reuse_i = 8'd1;
        p_ready_i   = 1'b1;
        predict(0, 0, 3, 1);
        a_valid_i = 1'b1; a_mant_i = a_m[0]; a_exp_i = a_e[0];
        b_valid_i = 1'b1; b_mant_i = b_m[0]; b_exp_i = b_e[0];
        @(negedge clk);
        checks++;
        if (a_ready_o !== 1'b1 || b_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL first_accept: got a_ready=%0b b_ready=%0b, required 1 1", a_ready_o, b_ready_o);
        end
        @(posedge clk);
        #1 a_valid_i = 1'b0; b_valid_i = 1'b0;
        @(negedge clk);
        checks++;
        if (p_valid_o !== 1'b0 || a_count_o !== 2'd1) begin
            errors++;
            $display("FAIL latency_t1: got valid=%0b a_count=%0d, required 0 1", p_valid_o, a_count_o);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (p_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_t2: got valid=%0b, required 1", p_valid_o);
        end
        @(posedge clk);
        #1;
        run_stream(1, 2, 1, 2, 0, 50);
    endtask

    task automatic test_reuse;
        cfg_reuse_i = 8'd3;
        p_ready_i   = 1'b1;
        predict(3, 3, 6, 3);
        run_stream(3, 2, 3, 3, 3, 50);
        checks++;
        if (a_count_o !== 2'd1) begin
            errors++;
            $display("FAIL reuse_a_free: got a_count=%0d, required 1", a_count_o);
        end
        run_stream(0, 0, 6, 2, 1, 50);
        checks++;
        if (a_count_o !== 2'd1) begin
            errors++;
            $display("FAIL reuse_a_held: got a_count=%0d, required 1", a_count_o);
        end
        run_stream(0, 0, 8, 1, 0, 50);
        checks++;
        if (a_count_o !== 2'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL reuse_a_drain: got a_count=%0d busy=%0b, required 0 0", a_count_o, busy_o);
        end
    endtask

    task automatic test_backpressure;
        cfg_reuse_i = 8'd1;
        p_ready_i   = 1'b0;
        predict(10, 10, 6, 1);
        run_stream(10, 1, 10, 6, 1000, 50);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++;
            if (p_valid_o !== 1'b1 || p_a_mant_o !== a_m[10] || p_b_mant_o !== b_m[10] || p_tag_o !== sb[0].tag) begin
                errors++;
                $display("FAIL hold_stable[%0d]: got valid=%0b am=%h bm=%h tag=%0d, required 1 %h %h %0d",
                         c, p_valid_o, p_a_mant_o, p_b_mant_o, p_tag_o, a_m[10], b_m[10], sb[0].tag);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (b_ready_o !== 1'b0 || b_count_o !== 3'd5) begin
            errors++;
            $display("FAIL b_full: got b_ready=%0b b_count=%0d, required 0 5", b_ready_o, b_count_o);
        end
        p_ready_i = 1'b1;
        run_stream(11, 5, 0, 0, 0, 100);
    endtask

    task automatic test_flush;
        cfg_reuse_i = 8'd4;
        p_ready_i   = 1'b1;
        predict(20, 20, 2, 4);
        run_stream(20, 1, 20, 2, 0, 50);
        checks++;
        if (a_count_o !== 2'd1) begin
            errors++;
            $display("FAIL flush_pre: got a_count=%0d, required 1", a_count_o);
        end
        cfg_flush_i = 1'b1;
        a_valid_i = 1'b1; a_mant_i = a_m[21]; a_exp_i = a_e[21];
        b_valid_i = 1'b1; b_mant_i = b_m[21]; b_exp_i = b_e[21];
        @(negedge clk);
        checks++;
        if (a_ready_o !== 1'b0 || b_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_ready: got a=%0b b=%0b, required 0 0", a_ready_o, b_ready_o);
        end
        @(posedge clk);
        #1 cfg_flush_i = 1'b0; a_valid_i = 1'b0; b_valid_i = 1'b0;
        exp_tag = '0;
        @(negedge clk);
        checks++;
        if (a_count_o !== 2'd0 || b_count_o !== 3'd0 || p_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got a=%0d b=%0d valid=%0b busy=%0b, required 0 0 0 0",
                     a_count_o, b_count_o, p_valid_o, busy_o);
        end
        @(posedge clk);
        #1 cfg_reuse_i = 8'd1;
        predict(22, 22, 1, 1);
        run_stream(22, 1, 22, 1, 0, 50);
    endtask

    task automatic test_tag_wrap;
        cfg_flush_i = 1'b1;
        @(posedge clk);
        #1 cfg_flush_i = 1'b0;
        exp_tag = '0;
        cfg_reuse_i = 8'd0;
        p_ready_i   = 1'b1;
        predict(30, 30, 6, 0);
        run_stream(30, 6, 30, 6, 0, 100);
    endtask

    task automatic test_async_reset_and_wrap;
        cfg_reuse_i = 8'd1;
        p_ready_i   = 1'b0;
        a_valid_i = 1'b1; a_mant_i = a_m[40]; a_exp_i = a_e[40];
        b_valid_i = 1'b1; b_mant_i = b_m[40]; b_exp_i = b_e[40];
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        #3 rst = 1'b1;
        #1 check_reset_values("async_reset");
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
        sb.delete();
        exp_tag = '0;
        @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            int base;
            base = 44 + k * 8;
            p_ready_i = 1'b0;
            predict(base, base, 6, 1);
            run_stream(base, 4, base, 6, 1000, 50);
            checks++;
            if (a_count_o !== 2'd3 || b_count_o !== 3'd5) begin
                errors++;
                $display("FAIL fill[%0d]: got a=%0d b=%0d, required 3 5", k, a_count_o, b_count_o);
            end
            p_ready_i = 1'b1;
            run_stream(base + 4, 2, 0, 0, 0, 100);
            checks++;
            if (busy_o !== 1'b0) begin
                errors++;
                $display("FAIL drain[%0d]: got busy=%0b, required 0", k, busy_o);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        exp_tag = '0;
        for (int i = 0; i < 64; i++) begin
            a_m[i] = MV'({$urandom(), $urandom()});
            a_e[i] = EV'($urandom());
            b_m[i] = MV'({$urandom(), $urandom()});
            b_e[i] = EV'($urandom());
        end
        rst = 1'b0;
        cfg_reuse_i = 8'd1;
        cfg_flush_i = 1'b0;
        a_valid_i = 1'b0; a_mant_i = '0; a_exp_i = '0;
        b_valid_i = 1'b0; b_mant_i = '0; b_exp_i = '0;
        p_ready_i = 1'b1;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        test_reset;
        test_one_to_one;
        test_reuse;
        test_backpressure;
        test_flush;
        test_tag_wrap;
        test_async_reset_and_wrap;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d pending pairs, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
